// File: rtl/split_fifo_pkg.sv
// split_pkg: shared word/beat types and sizing helpers for the split_fifo row splitter.
package split_pkg;

    localparam int unsigned DATA_WIDTH_DEF    = 32;
    localparam int unsigned BURST_LENGTH_DEF  = 32;
    localparam int unsigned KERNEL_LENGTH_DEF = 3;
    localparam int unsigned NUM_LANE_DEF      = 2;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef word_t [NUM_LANE_DEF-1:0]  lane_beat_t;

    function automatic int unsigned calc_depth(input int unsigned nl, input int unsigned bl);
        return nl * bl;
    endfunction

    // Pointer/select width, never narrower than one bit.
    function automatic int unsigned calc_pw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/split_fifo_if.sv
// split_fifo_if: beat-in / column-out handshake bundle of the row splitter.
interface split_fifo_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned K  = 3,
    parameter int unsigned NL = 2
);
    logic                  wen;
    logic                  ren;
    logic [NL-1:0][DW-1:0] din;
    logic                  valid;
    logic                  full_flag;
    logic                  empty_flag;
    logic [K-1:0][DW-1:0]  dout;

    modport master (output wen, ren, din, input valid, full_flag, empty_flag, dout);
    modport slave  (input wen, ren, din, output valid, full_flag, empty_flag, dout);
endinterface

// File: rtl/split_fifo_row_fifo.sv
// split_row_fifo: one row FIFO, NL-word write port, 1-word read port, occupancy-count flags.
module split_row_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned NL    = 2,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PW    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen_i,
    input  logic                     ren_i,
    input  logic [NL-1:0][DW-1:0]    din_i,
    output logic [DW-1:0]            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [PW-1:0]            wptr_o,
    output logic [PW-1:0]            rptr_o,
    output logic [DEPTH-1:0][DW-1:0] mem_o
);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [PW-1:0]            wptr_q, wptr_d;
    logic [PW-1:0]            rptr_q, rptr_d;
    logic [PW:0]              cnt_q, cnt_d;
    logic                     wr_ok, rd_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign wr_ok   = wen_i && !full_o;
    assign rd_ok   = ren_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_ok) begin
            wptr_d = wptr_q + PW'(NL);
            cnt_d  = cnt_d + (PW+1)'(NL);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
            cnt_d  = cnt_d - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int unsigned j = 0; j < NL; j++) begin
                mem_q[wptr_q + PW'(j)] <= din_i[j];
            end
        end
    end

    assign head_o = mem_q[rptr_q];
    assign wptr_o = wptr_q;
    assign rptr_o = rptr_q;
    assign mem_o  = mem_q;

endmodule

// File: rtl/split_fifo.sv
// split_fifo: round-robin row splitter feeding a KxK window stage, one column per read.
// Define SPLIT_DEBUG_EN to drive the *_checker ports from internal state; otherwise they read 0.
module split_fifo
    import split_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned BURST_LENGTH  = BURST_LENGTH_DEF,
    parameter int unsigned KERNEL_LENGTH = KERNEL_LENGTH_DEF,
    parameter int unsigned NUM_LANE      = NUM_LANE_DEF,
    localparam int unsigned DEPTH        = calc_depth(NUM_LANE, BURST_LENGTH),
    localparam int unsigned PW           = calc_pw(DEPTH)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    split_fifo_if.slave                                    bus,
    output logic [KERNEL_LENGTH:0][DATA_WIDTH-1:0]         data_i_checker,
    output logic [KERNEL_LENGTH-1:0]                       wen_i_checker,
    output logic [KERNEL_LENGTH-1:0]                       ren_i_checker,
    output logic [KERNEL_LENGTH-1:0][DEPTH-1:0][DATA_WIDTH-1:0] fifo_checker,
    output logic [KERNEL_LENGTH-1:0]                       full_flag_i_checker,
    output logic [KERNEL_LENGTH-1:0]                       empty_flag_i_checker,
    output logic [KERNEL_LENGTH-1:0][PW-1:0]               wptr_checker,
    output logic [KERNEL_LENGTH-1:0][PW-1:0]               rptr_checker
);

    localparam int unsigned SW = calc_pw(KERNEL_LENGTH);
    localparam int unsigned BW = calc_pw(BURST_LENGTH);

    logic [SW-1:0]                                  sel_q, sel_d;
    logic [BW-1:0]                                  beat_q, beat_d;
    logic                                           valid_q;
    logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]       dout_q;
    logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]       head_w;
    logic [KERNEL_LENGTH-1:0]                       wen_v, full_v, empty_v;
    logic [KERNEL_LENGTH-1:0][PW-1:0]               wptr_w, rptr_w;
    logic [KERNEL_LENGTH-1:0][DEPTH-1:0][DATA_WIDTH-1:0] mem_w;
    logic                                           wr_ok, rd_ok;

    assign bus.full_flag  = full_v[sel_q];
    assign bus.empty_flag = |empty_v;
    assign bus.valid      = valid_q;
    assign bus.dout       = dout_q;

    assign wr_ok = bus.wen && !bus.full_flag;
    assign rd_ok = bus.ren && !bus.empty_flag;

    // Row select follows accepted beats, not occupancy, since the last row may drain while filling.
    always_comb begin
        sel_d  = sel_q;
        beat_d = beat_q;
        if (wr_ok) begin
            if (beat_q == BW'(BURST_LENGTH - 1)) begin
                beat_d = '0;
                sel_d  = (sel_q == SW'(KERNEL_LENGTH - 1)) ? '0 : sel_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            valid_q <= rd_ok;
            if (rd_ok) begin
                dout_q <= head_w;
            end
        end
    end

    for (genvar k = 0; k < KERNEL_LENGTH; k++) begin : g_row
        assign wen_v[k] = wr_ok && (sel_q == SW'(k));

        split_row_fifo #(
            .DW    (DATA_WIDTH),
            .NL    (NUM_LANE),
            .DEPTH (DEPTH),
            .PW    (PW)
        ) u_row (
            .clk     (clk),
            .rst     (rst),
            .wen_i   (wen_v[k]),
            .ren_i   (rd_ok),
            .din_i   (bus.din),
            .head_o  (head_w[k]),
            .full_o  (full_v[k]),
            .empty_o (empty_v[k]),
            .wptr_o  (wptr_w[k]),
            .rptr_o  (rptr_w[k]),
            .mem_o   (mem_w[k])
        );
    end

`ifdef SPLIT_DEBUG_EN
    assign data_i_checker       = {bus.din[0], head_w};
    assign wen_i_checker        = wen_v;
    assign ren_i_checker        = {KERNEL_LENGTH{rd_ok}};
    assign fifo_checker         = mem_w;
    assign full_flag_i_checker  = full_v;
    assign empty_flag_i_checker = empty_v;
    assign wptr_checker         = wptr_w;
    assign rptr_checker         = rptr_w;
`else
    logic unused_dbg;
    assign unused_dbg           = ^{mem_w, wptr_w, rptr_w};
    assign data_i_checker       = '0;
    assign wen_i_checker        = '0;
    assign ren_i_checker        = '0;
    assign fifo_checker         = '0;
    assign full_flag_i_checker  = '0;
    assign empty_flag_i_checker = '0;
    assign wptr_checker         = '0;
    assign rptr_checker         = '0;
`endif

endmodule

// File: tb/tb_split_fifo.sv
// tb_split_fifo: directed bursts plus randomized rounds checked against a queue-based row model.
module tb_split_fifo;
    import split_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned BL    = 32;
    localparam int unsigned K     = 3;
    localparam int unsigned NL    = 2;
    localparam int unsigned DEPTH = NL * BL;
    localparam int unsigned PW    = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    split_fifo_if #(.DW(DW), .K(K), .NL(NL)) bus ();

    logic [K:0][DW-1:0]            data_i_checker;
    logic [K-1:0]                  wen_i_checker, ren_i_checker;
    logic [K-1:0][DEPTH-1:0][DW-1:0] fifo_checker;
    logic [K-1:0]                  full_flag_i_checker, empty_flag_i_checker;
    logic [K-1:0][PW-1:0]          wptr_checker, rptr_checker;

    split_fifo #(
        .DATA_WIDTH    (DW),
        .BURST_LENGTH  (BL),
        .KERNEL_LENGTH (K),
        .NUM_LANE      (NL)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus.slave),
        .data_i_checker       (data_i_checker),
        .wen_i_checker        (wen_i_checker),
        .ren_i_checker        (ren_i_checker),
        .fifo_checker         (fifo_checker),
        .full_flag_i_checker  (full_flag_i_checker),
        .empty_flag_i_checker (empty_flag_i_checker),
        .wptr_checker         (wptr_checker),
        .rptr_checker         (rptr_checker)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one queue per row, a row select and a beat count per burst.
    logic [DW-1:0]        mq [K][$];
    int unsigned          m_sel, m_beat;
    int unsigned          m_wcnt [K];
    int unsigned          m_rcnt [K];
    logic                 m_valid;
    logic [K-1:0][DW-1:0] m_dout;

    int unsigned          n_valid;
    bit                   seen_first;
    logic [K-1:0][DW-1:0] first_col, last_col;

    function automatic bit model_any_empty();
        for (int k = 0; k < K; k++) if (mq[k].size() == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare();
        check("valid", bus.valid, m_valid);
        for (int k = 0; k < K; k++) check($sformatf("dout[%0d]", k), bus.dout[k], m_dout[k]);
        check("empty_flag", bus.empty_flag, model_any_empty());
        check("full_flag", bus.full_flag, mq[m_sel].size() == DEPTH);
`ifdef SPLIT_DEBUG_EN
        for (int k = 0; k < K; k++) begin
            check($sformatf("wptr[%0d]", k), wptr_checker[k], m_wcnt[k] % DEPTH);
            check($sformatf("rptr[%0d]", k), rptr_checker[k], m_rcnt[k] % DEPTH);
            check($sformatf("empty_i[%0d]", k), empty_flag_i_checker[k], mq[k].size() == 0);
        end
`else
        check("dbg_ptrs_tied", {wptr_checker, rptr_checker}, 64'd0);
        check("dbg_flags_tied", {wen_i_checker, ren_i_checker, full_flag_i_checker,
                                 empty_flag_i_checker}, 64'd0);
        check("dbg_data_tied", {62'd0, |fifo_checker, |data_i_checker}, 64'd0);
`endif
        if (bus.valid) begin
            n_valid++;
            if (!seen_first) first_col = bus.dout;
            seen_first = 1'b1;
            last_col   = bus.dout;
        end
    endtask

    task automatic step(input bit w, input bit r, input lane_beat_t d);
        bit rd, wr;
        bus.wen = w;
        bus.ren = r;
        bus.din = d;
        rd = r && !model_any_empty();
        wr = w && (mq[m_sel].size() < DEPTH);
        m_valid = rd;
        if (rd) begin
            for (int k = 0; k < K; k++) begin
                m_dout[k] = mq[k].pop_front();
                m_rcnt[k]++;
            end
        end
        if (wr) begin
            for (int j = 0; j < NL; j++) mq[m_sel].push_back(d[j]);
            m_wcnt[m_sel] += NL;
            m_beat++;
            if (m_beat == BL) begin
                m_beat = 0;
                m_sel  = (m_sel + 1) % K;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        bus.din = '0;
        for (int k = 0; k < K; k++) begin
            mq[k].delete();
            m_wcnt[k] = 0;
            m_rcnt[k] = 0;
        end
        m_sel   = 0;
        m_beat  = 0;
        m_valid = 1'b0;
        m_dout  = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();
    endtask

    // Feeds beats base+i+j; stops early (mid-burst) once stop_at beats were sent.
    task automatic burst(input int unsigned base, input bit rnd, input int unsigned ren_pct,
                         input int unsigned stop_at);
        int unsigned i;
        lane_beat_t  d;
        bit          r;
        i = 0;
        while (i < BL) begin
            if (i == stop_at) return;
            for (int j = 0; j < NL; j++) d[j] = DW'(base + i + j);
            r = ($urandom_range(99) < ren_pct);
            if (rnd && $urandom_range(3) == 0) begin
                step(1'b0, r, d);
            end else begin
                step(1'b1, r, d);
                i++;
            end
        end
    endtask

    task automatic drain();
        lane_beat_t d;
        for (int n = 0; n < 3 * DEPTH; n++) begin
            d = {DW'($urandom), DW'($urandom)};
            step(1'b0, 1'b1, d);
        end
    endtask

    lane_beat_t                      xd;
    logic [K-1:0][DEPTH-1:0][DW-1:0] snap;

    initial begin
        rst = 1'b1;
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        bus.din = '0;

        // Directed: three bursts with ren held high, then drain.
        do_reset();
        n_valid    = 0;
        seen_first = 1'b0;
        burst(1, 1'b0, 100, BL);
`ifdef SPLIT_DEBUG_EN
        for (int i = 0; i < BL; i++)
            for (int j = 0; j < NL; j++)
                check("fifo0_entry", fifo_checker[0][NL*i+j], 64'(1 + i + j));
`endif
        burst(2, 1'b0, 100, BL);
        burst(3, 1'b0, 100, BL);
        drain();
        check("valid_pulses", n_valid, 64'd64);
        check("first_col0", first_col[0], 64'd1);
        check("first_col1", first_col[1], 64'd2);
        check("first_col2", first_col[2], 64'd3);
        check("last_col0", last_col[0], 64'd33);
        check("last_col1", last_col[1], 64'd34);
        check("last_col2", last_col[2], 64'd35);

        // Write while the selected row is full is dropped.
        do_reset();
        for (int r = 0; r < K; r++) burst(10 * (r + 1), 1'b0, 0, BL);
        check("full_after_fill", bus.full_flag, 1'b1);
        snap = fifo_checker;
        xd = {DW'(32'hDEAD), DW'(32'hBEEF)};
        step(1'b1, 1'b0, xd);
        step(1'b1, 1'b0, xd);
        check("dropped_contents", fifo_checker == snap, 1'b1);
        drain();

        // Read with only one row filled is ignored.
        do_reset();
        burst(20, 1'b0, 0, BL);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, xd);

        // Reset mid-burst, next burst lands in row 0.
        burst(40, 1'b1, 50, 17);
        do_reset();
        burst(50, 1'b0, 100, BL);
`ifdef SPLIT_DEBUG_EN
        check("after_reset_row0", fifo_checker[0][0], 64'd50);
`endif

        // Randomized rounds.
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset();
            burst($urandom, 1'b1, $urandom_range(100), $urandom_range(BL - 1, 1));
            do_reset();
            for (int r = 0; r < K; r++) burst($urandom, 1'b1, $urandom_range(100), BL);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
